// File: rtl/float_mult_arbiter_pkg.sv
// Shared types and sizing helpers for the float multiplier arbiter.
package float_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      SETTLE,
      WAIT,
      DONE
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Wide enough to hold TIMEOUT itself; a disabled timeout still gets one bit.
   function automatic int cnt_width(input int t);
      return (t < 2) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/float_mult_arbiter_if.sv
// Request/operand bus between clients, the arbiter and the external multiplier.
interface float_mult_arbiter_if #(
   parameter int BITS    = 16,
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]      in_req;
   logic [NUM_REQ*BITS-1:0] in_a;
   logic [NUM_REQ*BITS-1:0] in_b;
   logic [NUM_REQ-1:0]      out_grant;
   logic [NUM_REQ-1:0]      out_ack;
   logic [BITS-1:0]         out_prod;
   logic                    out_timeout;
   logic                    out_busy;
   logic [BITS-1:0]         mul_a;
   logic [BITS-1:0]         mul_b;
   logic                    mul_start;
   logic                    mul_finished;
   logic [BITS-1:0]         mul_prod;

   modport slave (
      input  in_req, in_a, in_b, mul_finished, mul_prod,
      output out_grant, out_ack, out_prod, out_timeout, out_busy, mul_a, mul_b, mul_start
   );

   modport master (
      output in_req, in_a, in_b, mul_finished, mul_prod,
      input  out_grant, out_ack, out_prod, out_timeout, out_busy, mul_a, mul_b, mul_start
   );
endinterface

// File: rtl/float_mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);
   logic [IW-1:0] cand [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(ptr) + gi) % N);
   end

   // Scan from the far end so the candidate closest to ptr is the one that sticks.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            idx   = cand[k];
            valid = 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = valid && (idx == IW'(gi));
   end
endmodule

// File: rtl/float_mult_arbiter.sv
// Round-robin sharing of one external float multiplier between NUM_REQ clients.
module float_mult_arbiter
   import float_arb_pkg::*;
#(
   parameter int BITS     = 16,
   parameter int EXP_BITS = 5,
   parameter int NUM_REQ  = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic                in_clk,
   input  logic                in_rst,
   float_mult_arbiter_if.slave bus
);
   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = cnt_width(TIMEOUT);

   if (EXP_BITS < 1 || EXP_BITS > BITS - 2 || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 0) begin : g_bad_cfg
      $error("float_mult_arbiter: inconsistent parameters");
   end

   arb_state_t         state_reg, state_next;
   logic [IW-1:0]      ptr_reg, ptr_next;
   logic [IW-1:0]      idx_reg, idx_next;
   logic [NUM_REQ-1:0] grant_reg, grant_next;
   logic [BITS-1:0]    a_reg, a_next;
   logic [BITS-1:0]    b_reg, b_next;
   logic [BITS-1:0]    prod_reg, prod_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic               flag_reg, flag_next;

   logic [NUM_REQ-1:0] pick_grant;
   logic [IW-1:0]      pick_idx;
   logic               pick_valid;
   logic [BITS-1:0]    op_a [NUM_REQ];
   logic [BITS-1:0]    op_b [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ops
      assign op_a[gi] = bus.in_a[gi*BITS +: BITS];
      assign op_b[gi] = bus.in_b[gi*BITS +: BITS];
   end

   rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
      .req   (bus.in_req),
      .ptr   (ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         idx_reg   <= '0;
         grant_reg <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         prod_reg  <= '0;
         cnt_reg   <= '0;
         flag_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         idx_reg   <= idx_next;
         grant_reg <= grant_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         prod_reg  <= prod_next;
         cnt_reg   <= cnt_next;
         flag_reg  <= flag_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      idx_next   = idx_reg;
      grant_next = grant_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      prod_next  = prod_reg;
      cnt_next   = cnt_reg;
      flag_next  = flag_reg;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               grant_next = pick_grant;
               idx_next   = pick_idx;
               a_next     = op_a[pick_idx];
               b_next     = op_b[pick_idx];
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = SETTLE;
         // The finished flag may still be high from the previous product here.
         SETTLE: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            if (bus.mul_finished) begin
               prod_next  = bus.mul_prod;
               state_next = DONE;
            end else if ((TIMEOUT > 0) && (cnt_reg == CW'(TIMEOUT - 1))) begin
               prod_next  = '0;
               flag_next  = 1'b1;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            ptr_next   = (idx_reg == IW'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
            grant_next = '0;
            flag_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.out_grant   = grant_reg;
   assign bus.out_ack     = (state_reg == DONE) ? grant_reg : '0;
   assign bus.out_timeout = (state_reg == DONE) && flag_reg;
   assign bus.out_busy    = (state_reg != IDLE);
   assign bus.out_prod    = prod_reg;
   assign bus.mul_a       = a_reg;
   assign bus.mul_b       = b_reg;
   assign bus.mul_start   = (state_reg == ISSUE);
endmodule

// File: tb/tb_float_mult_arbiter.sv
// Randomized bench for float_mult_arbiter against a transaction-level reference and a multiplier model.
module tb_float_mult_arbiter;
   localparam int BITS = 16;
   localparam int NR   = 4;
   localparam int TO   = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   float_mult_arbiter_if #(.BITS(BITS), .NUM_REQ(NR)) bus ();

   float_mult_arbiter #(.BITS(BITS), .EXP_BITS(5), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .in_clk (clk),
      .in_rst (rst),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Known IEEE half products, otherwise an arbitrary but deterministic mixing function.
   function automatic logic [15:0] mul_fn(input logic [15:0] a, input logic [15:0] b);
      if (a == 16'h5640 && b == 16'hcc00) return 16'he640;
      if (a == 16'h3800 && b == 16'hb400) return 16'hb000;
      return {a[7:0] ^ b[15:8], a[15:8] + b[7:0]};
   endfunction

   function automatic int lat_fn(input logic [15:0] a, input logic [15:0] b);
      return int'({16'h0, a ^ b} % 32'd7);
   endfunction

   // Multiplier model: finished stays high after a product until the next start is consumed.
   bit          hang_mode = 1'b0;
   logic        m_fin, m_pend, m_hang;
   logic [15:0] m_prod;
   int          m_cnt;

   always @(posedge clk) begin
      if (rst) begin
         m_fin  <= 1'b0;
         m_prod <= '0;
         m_pend <= 1'b0;
         m_hang <= 1'b0;
         m_cnt  <= 0;
      end else if (bus.mul_start) begin
         m_pend <= 1'b1;
         m_hang <= hang_mode;
         m_cnt  <= lat_fn(bus.mul_a, bus.mul_b);
      end else if (m_pend && m_hang) begin
         m_fin <= 1'b0;
      end else if (m_pend) begin
         if (m_cnt == 0) begin
            m_fin  <= 1'b1;
            m_prod <= mul_fn(bus.mul_a, bus.mul_b);
            m_pend <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
            m_fin <= 1'b0;
         end
      end
   end

   assign bus.mul_finished = m_fin;
   assign bus.mul_prod     = m_prod;

   // Reference: one operation at a time, timing derived from the multiplier latency.
   bit          chk_on = 1'b0;
   int          cyc = 0;
   bit          m_act = 1'b0;
   bit          m_to = 1'b0;
   int          m_gi = 0, m_ptr = 0, m_issue = 0, m_ack = 0, m_lat = 0;
   logic [15:0] m_a = '0, m_b = '0, m_res = '0, m_hold = '0, e_ma = '0, e_mb = '0;
   logic [NR-1:0] ack_model = '0;
   logic [NR-1:0] e_grant, e_ack;
   bit          in_op, e_done, ck_found;
   int          start_cyc = 0, n_starts = 0;
   int          log_idx[$], log_prod[$], log_to[$], log_lat[$];

   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            cyc++;
            ack_model = '0;
            in_op   = m_act && (cyc >= m_issue);
            e_done  = m_act && (cyc == m_ack);
            e_grant = '0;
            if (in_op) e_grant[m_gi] = 1'b1;
            e_ack = e_done ? e_grant : '0;
            check_val("grant", 32'(bus.out_grant), 32'(e_grant));
            check_val("ack", 32'(bus.out_ack), 32'(e_ack));
            check_val("timeout", 32'(bus.out_timeout), 32'(e_done && m_to));
            check_val("busy", 32'(bus.out_busy), 32'(in_op));
            check_val("start", 32'(bus.mul_start), 32'(m_act && (cyc == m_issue)));
            check_val("mul_a", 32'(bus.mul_a), 32'(e_ma));
            check_val("mul_b", 32'(bus.mul_b), 32'(e_mb));
            check_val("prod", 32'(bus.out_prod), 32'(e_done ? m_res : m_hold));
            if (bus.mul_start) begin
               n_starts++;
               start_cyc = cyc;
            end
            if (bus.out_ack != '0) begin
               for (int i = 0; i < NR; i++) if (bus.out_ack[i]) log_idx.push_back(i);
               log_prod.push_back(int'(bus.out_prod));
               log_to.push_back(int'(bus.out_timeout));
               log_lat.push_back(cyc - start_cyc);
               $display("ack idx=%0d prod=%h timeout=%0d cycle=%0d", m_gi, bus.out_prod, bus.out_timeout, cyc);
            end
            if (rst) begin
               m_act  = 1'b0;
               m_ptr  = 0;
               m_hold = '0;
               e_ma   = '0;
               e_mb   = '0;
            end else if (e_done) begin
               m_act         = 1'b0;
               m_hold        = m_res;
               m_ptr         = (m_gi + 1) % NR;
               ack_model[m_gi] = 1'b1;
            end else if (!m_act && bus.in_req != '0) begin
               ck_found = 1'b0;
               for (int k = 0; k < NR; k++) begin
                  if (!ck_found && bus.in_req[(m_ptr + k) % NR]) begin
                     ck_found = 1'b1;
                     m_gi     = (m_ptr + k) % NR;
                  end
               end
               m_a     = bus.in_a[m_gi*BITS +: BITS];
               m_b     = bus.in_b[m_gi*BITS +: BITS];
               e_ma    = m_a;
               e_mb    = m_b;
               m_issue = cyc + 1;
               if (hang_mode) begin
                  m_to  = 1'b1;
                  m_ack = m_issue + 2 + TO;
               end else begin
                  m_lat = lat_fn(m_a, m_b);
                  m_to  = (m_lat >= TO);
                  m_ack = m_issue + 2 + ((m_lat + 1 < TO) ? m_lat + 1 : TO);
               end
               m_res = m_to ? 16'h0 : mul_fn(m_a, m_b);
               m_act = 1'b1;
            end
         end
      end
   end

   // Clients: hold req until ack, then reload from nxt_* while operations remain.
   logic [NR-1:0] req_v = '0;
   logic [15:0]   op_a [NR];
   logic [15:0]   op_b [NR];
   logic [15:0]   nxt_a [NR];
   logic [15:0]   nxt_b [NR];
   int            rem [NR];
   bit            rand_mode = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (ack_model[i]) begin
            rem[i]--;
            if (rem[i] > 0) begin
               op_a[i]  = nxt_a[i];
               op_b[i]  = nxt_b[i];
               nxt_a[i] = 16'($urandom);
               nxt_b[i] = 16'($urandom);
               req_v[i] = 1'b1;
            end else begin
               req_v[i] = 1'b0;
            end
         end else if (rand_mode && m_act && m_gi == i && cyc >= m_issue) begin
            if ($urandom_range(0, 3) == 0) req_v[i] = 1'b0;
            if ($urandom_range(0, 3) == 0) op_a[i] = 16'($urandom);
         end
      end
      bus.in_req = req_v;
      for (int i = 0; i < NR; i++) begin
         bus.in_a[i*BITS +: BITS] = op_a[i];
         bus.in_b[i*BITS +: BITS] = op_b[i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic start_op(input int i, input logic [15:0] a, input logic [15:0] b, input int n);
      op_a[i]  = a;
      op_b[i]  = b;
      rem[i]   = n;
      req_v[i] = 1'b1;
   endtask

   function automatic bit pending();
      bit p = m_act || (req_v != '0);
      for (int i = 0; i < NR; i++) if (rem[i] > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input string tag, input int budget);
      int n = 0;
      tick();
      while (pending() && n < budget) begin
         tick();
         n++;
      end
      check_val(tag, 32'(n < budget), 32'd1);
   endtask

   initial begin
      int base, n, s0;
      for (int i = 0; i < NR; i++) begin
         op_a[i] = '0; op_b[i] = '0; rem[i] = 0;
         nxt_a[i] = 16'($urandom); nxt_b[i] = 16'($urandom);
      end
      bus.in_req = '0;
      bus.in_a   = '0;
      bus.in_b   = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b1;
      tick();
      rst = 1'b0;

      // Single request with a real half-precision product.
      base = log_idx.size();
      s0   = n_starts;
      start_op(0, 16'h5640, 16'hcc00, 1);
      drain("single_drain", 200);
      check_val("single_starts", 32'(n_starts - s0), 32'd1);
      check_val("single_idx", 32'(log_idx[base]), 32'd0);
      check_val("single_prod", 32'(log_prod[base]), 32'he640);
      check_val("single_to", 32'(log_to[base]), 32'd0);

      // Two simultaneous requests from pointer 0.
      do_reset();
      base = log_idx.size();
      start_op(1, 16'h3800, 16'hb400, 1);
      start_op(2, 16'h5640, 16'hcc00, 1);
      drain("pair_drain", 200);
      check_val("pair_count", 32'(log_idx.size() - base), 32'd2);
      check_val("pair_first", 32'(log_idx[base]), 32'd1);
      check_val("pair_first_prod", 32'(log_prod[base]), 32'hb000);
      check_val("pair_second", 32'(log_idx[base+1]), 32'd2);
      check_val("pair_second_prod", 32'(log_prod[base+1]), 32'he640);

      // Fairness: two requesters holding req for four operations each.
      base = log_idx.size();
      start_op(0, 16'($urandom), 16'($urandom), 4);
      start_op(3, 16'($urandom), 16'($urandom), 4);
      drain("fair_drain", 500);
      check_val("fair_count", 32'(log_idx.size() - base), 32'd8);
      for (int k = base + 1; k < base + 8; k++)
         check_val("fair_alt", 32'(log_idx[k] != log_idx[k-1]), 32'd1);

      // Stale finished: second operation has latency 1, finished still high from the first.
      base = log_idx.size();
      nxt_a[1] = 16'h5640;
      nxt_b[1] = 16'hcc00;
      start_op(1, 16'h3800, 16'hb400, 2);
      drain("stale_drain", 200);
      check_val("stale_prod0", 32'(log_prod[base]), 32'hb000);
      check_val("stale_prod1", 32'(log_prod[base+1]), 32'he640);
      check_val("stale_lat1", 32'(log_lat[base+1]), 32'd4);

      // Timeout: a hanging multiplier, then a normal pending request.
      base = log_idx.size();
      hang_mode = 1'b1;
      start_op(2, 16'h1234, 16'h4321, 1);
      n = 0;
      tick();
      while (!(m_act && cyc >= m_issue) && n < 50) begin
         tick();
         n++;
      end
      check_val("to_grant_wait", 32'(n < 50), 32'd1);
      hang_mode = 1'b0;
      start_op(0, 16'h2222, 16'h0101, 1);
      drain("to_drain", 300);
      check_val("to_idx", 32'(log_idx[base]), 32'd2);
      check_val("to_flag", 32'(log_to[base]), 32'd1);
      check_val("to_prod", 32'(log_prod[base]), 32'd0);
      check_val("to_lat", 32'(log_lat[base]), 32'(2 + TO));
      check_val("to_next_idx", 32'(log_idx[base+1]), 32'd0);
      check_val("to_next_flag", 32'(log_to[base+1]), 32'd0);
      check_val("to_next_prod", 32'(log_prod[base+1]), 32'(mul_fn(16'h2222, 16'h0101)));

      // Reset while waiting on a latency-6 product; the held request then completes.
      base = log_idx.size();
      start_op(3, 16'h0006, 16'h0000, 1);
      n = 0;
      tick();
      while (!(m_act && cyc >= m_issue + 2) && n < 50) begin
         tick();
         n++;
      end
      check_val("rst_wait", 32'(n < 50), 32'd1);
      do_reset();
      drain("rst_drain", 200);
      check_val("rst_count", 32'(log_idx.size() - base), 32'd1);
      check_val("rst_prod", 32'(log_prod[base]), 32'(mul_fn(16'h0006, 16'h0000)));

      // Random traffic with mid-operation drops and operand changes.
      rand_mode = 1'b1;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NR; i++)
            if ($urandom_range(0, 3) != 0)
               start_op(i, 16'($urandom), 16'($urandom), int'($urandom_range(1, 4)));
         drain("rand_drain", 2000);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/float_mult_arbiter.md
Name: float_mult_arbiter

Overview:
- Shares one float_multiplier instance between NUM_REQ requesters using round-robin arbitration.
- Latches the granted requester's operands and pulses the multiplier start.
- Waits for the multiplier's finished flag, registers the product and acknowledges the requester.
- Sits between client blocks (display drivers, small sequencers) and the multiplier; the multiplier is instantiated outside and wired to the mul_* ports.

Parameters:
- BITS, 16, float word width (sign + exponent + mantissa).
- EXP_BITS, 5, exponent width. Passed through for the consistency check only; the arbiter does no float arithmetic.
- NUM_REQ, 4, number of requesters, 2..8.
- TIMEOUT, 255, maximum cycles spent in WAIT before abort; 0 disables the timeout.

Ports:
- in_clk  input  1  system clock
- in_rst  input  1  synchronous, active-high reset
- in_req  input  NUM_REQ  request lines, one per requester, level
- in_a  input  NUM_REQ*BITS  operand A; requester i uses bits [i*BITS +: BITS]
- in_b  input  NUM_REQ*BITS  operand B, same packing
- out_grant  output  NUM_REQ  one-hot; identifies the requester owning the current operation
- out_ack  output  NUM_REQ  one-cycle pulse to the requester whose operation completed
- out_prod  output  BITS  product of the last completed operation; held until the next completion
- out_timeout  output  1  high together with out_ack when the operation was aborted
- out_busy  output  1  high in every state except IDLE
- mul_a, mul_b  output  BITS  operands to the multiplier; held stable from ISSUE until DONE
- mul_start  output  1  start pulse to the multiplier
- mul_finished  input  1  multiplier finished flag
- mul_prod  input  BITS  multiplier product

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0. Reset mid-operation aborts immediately with no ack. The multiplier shares in_rst.
- States: IDLE, ISSUE, SETTLE, WAIT, DONE.
- IDLE, when any in_req is high:
  - Pick the first set request scanning from pointer, pointer+1, ... mod NUM_REQ.
  - Register out_grant (one-hot) and latch that requester's operands into mul_a/mul_b.
  - Go to ISSUE. out_grant is visible the cycle after the request is first seen.
- ISSUE: mul_start=1 for exactly this cycle; go to SETTLE.
- SETTLE: one cycle in which mul_finished is ignored, because it can still be high from the previous operation. Go to WAIT.
- WAIT: stay until mul_finished=1, then register mul_prod into out_prod and go to DONE.
  - If TIMEOUT>0, a counter is cleared on entry and incremented each cycle.
  - When the counter reaches TIMEOUT without mul_finished: out_prod=0, set the timeout flag, go to DONE.
- DONE:
  - out_ack pulses for the granted index; out_timeout equals the flag.
  - Pointer becomes granted index+1 mod NUM_REQ.
  - Clear out_grant and the flag; go to IDLE.
- out_ack and out_timeout are 0 in every state other than DONE.
- Minimum request-to-ack latency: 4 cycles + multiplier latency.
- Requester contract: hold req and operands until ack. Operands are sampled only at grant, so later changes are ignored.
- A request dropped mid-operation does not abort; the operation completes and the ack still pulses.
- A requester holding req after its ack re-arbitrates from IDLE. It ranks last behind the other requests, so it cannot starve them.
- New requests arriving while busy wait; there is no queue beyond the req levels.
- Only one operation is in flight; there is no pipelining.

Decomposition:
- Package float_arb_pkg holds:
  - state enum (IDLE, ISSUE, SETTLE, WAIT, DONE)
  - localparam functions for clog2(NUM_REQ) index width and timeout counter width
- Sub-module rr_picker (combinational):
  - inputs: request vector, pointer
  - outputs: one-hot grant, binary index, valid
  - Natural to test standalone.

Test Plan:
- Single request, real float_multiplier: req[0], a=0x5640 (+100), b=0xcc00 (-16) -> one start pulse; ack[0] pulse with out_prod=0xe640; out_timeout=0; out_busy low the cycle after DONE.
- Simultaneous req[1] and req[2], pointer 0:
  - req[1] a=0x3800, b=0xb400 -> ack[1] first with prod=0xb000.
  - req[2] a=0x5640, b=0xcc00 -> ack[2] next with 0xe640.
- Fairness: req[0] and req[3] held permanently -> grants alternate 0,3,0,3 across 8 operations; no requester is granted twice in a row while the other waits.
- Stale finished: multiplier model keeps mul_finished high after an operation; issue a second operation -> product is taken only after the new finish. out_prod never shows the stale value for the new ack.
- Timeout: TIMEOUT=10, model never asserts finished -> ack with out_timeout=1 and out_prod=0 exactly 10 cycles after WAIT entry; next pending request is served normally.
- Reset mid-WAIT: in_rst high for 1 cycle -> all outputs 0 next cycle, no ack, pointer 0; a fresh request then completes normally.
